// File: rtl/lsu_mem_ctrl_pkg.sv
// Shared types and constants for the MEM-stage load/store controller.
// Includes the funct3 encodings, the FSM state type and the request fault check.
package lsu_pkg;

    localparam int WORD_W = 32;
    localparam int ADDR_W = 32;

    localparam logic [2:0] F3_B  = 3'd0;
    localparam logic [2:0] F3_H  = 3'd1;
    localparam logic [2:0] F3_W  = 3'd2;
    localparam logic [2:0] F3_BU = 3'd4;
    localparam logic [2:0] F3_HU = 3'd5;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_WRITE = 2'd2,
        S_RESP  = 2'd3
    } state_e;

    // Illegal funct3 for the direction, misaligned access, or word index beyond depth.
    function automatic logic req_fault(input logic we, input logic [2:0] f3,
                                       input logic [ADDR_W-1:0] addr,
                                       input int unsigned depth);
        logic bad_f3;
        logic misal;
        logic oor;
        bad_f3 = we ? (f3 > F3_W) : (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7);
        misal  = (f3[1:0] == 2'd1 && addr[0]) || (f3[1:0] == 2'd2 && addr[1:0] != 2'd0);
        oor    = {2'b00, addr[ADDR_W-1:2]} >= depth;
        return bad_f3 || misal || oor;
    endfunction

endpackage

// File: rtl/lsu_mem_ctrl_if.sv
// Request/response handshake between the execute stage and the load/store controller.
interface lsu_mem_ctrl_if;
    import lsu_pkg::*;

    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [2:0]        req_funct3;
    logic [ADDR_W-1:0] req_addr;
    logic [WORD_W-1:0] req_wdata;
    logic              resp_valid;
    logic [WORD_W-1:0] resp_rdata;
    logic              resp_fault;

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_fault
    );

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_fault
    );

endinterface

// File: rtl/lsu_mem_ctrl_align.sv
// Combinational lane logic: store merge into a full word and load extract/extend.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [WORD_W-1:0] word_i,
    input  logic [WORD_W-1:0] wdata_i,
    input  logic [2:0]        funct3_i,
    input  logic [1:0]        lane_i,
    output logic [WORD_W-1:0] merged_o,
    output logic [WORD_W-1:0] rdata_o
);

    logic [7:0]  lane_new [4];
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        localparam logic [1:0] LANE = 2'(gi);
        // A halfword store feeds wdata[7:0] to the low lane and wdata[15:8] to the high lane.
        assign lane_new[gi] =
            (funct3_i == F3_W)                         ? wdata_i[gi*8 +: 8] :
            (funct3_i == F3_B && lane_i == LANE)       ? wdata_i[7:0] :
            (funct3_i == F3_H && lane_i[1] == LANE[1]) ? wdata_i[(gi%2)*8 +: 8] :
                                                         word_i[gi*8 +: 8];
    end

    assign merged_o = {lane_new[3], lane_new[2], lane_new[1], lane_new[0]};

    always_comb begin
        byte_sel = word_i[7:0];
        case (lane_i)
            2'd1:    byte_sel = word_i[15:8];
            2'd2:    byte_sel = word_i[23:16];
            2'd3:    byte_sel = word_i[31:24];
            default: byte_sel = word_i[7:0];
        endcase
        half_sel = lane_i[1] ? word_i[31:16] : word_i[15:0];

        rdata_o = word_i;
        case (funct3_i)
            F3_B:    rdata_o = {{24{byte_sel[7]}}, byte_sel};
            F3_BU:   rdata_o = {24'b0, byte_sel};
            F3_H:    rdata_o = {{16{half_sel[15]}}, half_sel};
            F3_HU:   rdata_o = {16'b0, half_sel};
            default: rdata_o = word_i;
        endcase
    end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// MEM-stage load/store controller: one request at a time, sub-word stores by
// read-modify-write, faulting requests complete without touching memory.
module lsu_mem_ctrl
    import lsu_pkg::*;
#(
    parameter int unsigned DEPTH = 1024
) (
    input  logic              clk2,
    input  logic              rst_n,
    lsu_mem_ctrl_if.slave     bus,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_en_w,
    output logic [WORD_W-1:0] mem_wdata,
    input  logic [WORD_W-1:0] mem_rdata
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [WORD_W-1:0] wdata_q, wdata_d;
    logic [2:0]        funct3_q, funct3_d;
    logic              we_q, we_d;
    logic              fault_q, fault_d;
    logic [WORD_W-1:0] buf_q, buf_d;

    logic [WORD_W-1:0] merged_word;
    logic [WORD_W-1:0] load_data;

    lsu_align u_align (
        .word_i   (buf_q),
        .wdata_i  (wdata_q),
        .funct3_i (funct3_q),
        .lane_i   (addr_q[1:0]),
        .merged_o (merged_word),
        .rdata_o  (load_data)
    );

    always_ff @(posedge clk2 or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            addr_q   <= '0;
            wdata_q  <= '0;
            funct3_q <= '0;
            we_q     <= 1'b0;
            fault_q  <= 1'b0;
            buf_q    <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            funct3_q <= funct3_d;
            we_q     <= we_d;
            fault_q  <= fault_d;
            buf_q    <= buf_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        funct3_d = funct3_q;
        we_d     = we_q;
        fault_d  = fault_q;
        buf_d    = buf_q;
        case (state_q)
            S_IDLE: begin
                if (bus.req_valid) begin
                    addr_d   = bus.req_addr;
                    wdata_d  = bus.req_wdata;
                    funct3_d = bus.req_funct3;
                    we_d     = bus.req_we;
                    fault_d  = req_fault(bus.req_we, bus.req_funct3, bus.req_addr, DEPTH);
                    if (fault_d)
                        state_d = S_RESP;
                    else if (bus.req_we && bus.req_funct3 == F3_W)
                        state_d = S_WRITE;
                    else
                        state_d = S_READ;
                end
            end
            S_READ: begin
                buf_d   = mem_rdata;
                state_d = we_q ? S_WRITE : S_RESP;
            end
            S_WRITE: state_d = S_RESP;
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs decode straight from state so an async reset clears them at once.
    assign bus.req_ready  = (state_q == S_IDLE);
    assign bus.resp_valid = (state_q == S_RESP);
    assign bus.resp_fault = (state_q == S_RESP) && fault_q;
    assign bus.resp_rdata = (state_q == S_RESP && !fault_q && !we_q) ? load_data : '0;

    assign mem_addr  = {2'b00, addr_q[ADDR_W-1:2]};
    assign mem_en_w  = (state_q == S_WRITE) && !fault_q;
    assign mem_wdata = mem_en_w ? merged_word : '0;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Scoreboard bench for lsu_mem_ctrl: driver pushes expected responses and writes,
// monitor pops and compares whenever the controller responds or writes memory.
module tb_lsu_mem_ctrl;
    import lsu_pkg::*;

    typedef struct {
        logic        fault;
        logic [31:0] rdata;
        int          cyc;
    } resp_t;

    typedef struct {
        logic [31:0] idx;
        logic [31:0] data;
    } wr_t;

    logic        clk2;
    logic        rst_n;
    logic [31:0] mem_addr;
    logic        mem_en_w;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic [31:0] data_mem [1024] = '{default: '0};

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;
    int prev_accept = 0;

    resp_t exp_q [$];
    wr_t   wr_q  [$];

    lsu_mem_ctrl_if bus ();

    lsu_mem_ctrl #(.DEPTH(1024)) dut (
        .clk2      (clk2),
        .rst_n     (rst_n),
        .bus       (bus),
        .mem_addr  (mem_addr),
        .mem_en_w  (mem_en_w),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    initial begin
        clk2 = 1'b0;
        forever #5 clk2 = ~clk2;
    end

    always @(posedge clk2) cyc <= cyc + 1;

    // Word-addressed data memory: combinational read, write on the falling edge.
    assign mem_rdata = data_mem[mem_addr[9:0]];
    always @(negedge clk2) begin
        if (mem_en_w) data_mem[mem_addr[9:0]] <= mem_wdata;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %08h expected %08h", name, act, exp);
    endtask

    always @(negedge clk2) begin
        resp_t e;
        wr_t   w;
        if (rst_n && bus.resp_valid) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_resp", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("resp_fault", {31'b0, bus.resp_fault}, {31'b0, e.fault});
                chk("resp_rdata", bus.resp_rdata, e.rdata);
                chk("resp_cycle", cyc, e.cyc);
                chk("ready_in_resp", {31'b0, bus.req_ready}, 32'd0);
                $display("resp  cyc=%0d fault=%0b rdata=%08h", cyc, bus.resp_fault, bus.resp_rdata);
            end
        end
        if (mem_en_w) begin
            if (wr_q.size() == 0) begin
                chk("unexpected_write", 32'd1, 32'd0);
            end else begin
                w = wr_q.pop_front();
                chk("wr_idx", mem_addr, w.idx);
                chk("wr_data", mem_wdata, w.data);
                $display("write cyc=%0d idx=%0d data=%08h", cyc, mem_addr, mem_wdata);
            end
        end
    end

    // lat: cycles from accept to the response cycle; intv: expected gap from previous accept (0 = none).
    task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic exp_fault,
                         input logic [31:0] exp_rdata, input int lat,
                         input logic exp_wr, input logic [31:0] wr_data,
                         input int intv, input logic hold);
        int waits;
        resp_t e;
        wr_t   w;
        waits = 0;
        @(negedge clk2);
        bus.req_valid  = 1'b1;
        bus.req_we     = we;
        bus.req_funct3 = f3;
        bus.req_addr   = addr;
        bus.req_wdata  = wdata;
        while (!bus.req_ready && waits < 50) begin
            @(negedge clk2);
            waits++;
        end
        if (waits >= 50) begin
            chk("accept_timeout", 32'd1, 32'd0);
            bus.req_valid = 1'b0;
            return;
        end
        if (intv != 0) chk("issue_interval", cyc - prev_accept, intv);
        prev_accept = cyc;
        e.fault = exp_fault;
        e.rdata = exp_rdata;
        e.cyc   = cyc + lat;
        exp_q.push_back(e);
        if (exp_wr) begin
            w.idx  = {2'b00, addr[31:2]};
            w.data = wr_data;
            wr_q.push_back(w);
        end
        $display("issue cyc=%0d we=%0b f3=%0d addr=%08h wdata=%08h", cyc, we, f3, addr, wdata);
        @(posedge clk2);
        #1;
        chk("ready_after_accept", {31'b0, bus.req_ready}, 32'd0);
        if (!hold) bus.req_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk2);
        @(negedge clk2);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n          = 1'b0;
        bus.req_valid  = 1'b0;
        bus.req_we     = 1'b0;
        bus.req_funct3 = 3'd0;
        bus.req_addr   = 32'd0;
        bus.req_wdata  = 32'd0;
        #2;
        chk("rst_ready",      {31'b0, bus.req_ready},  32'd1);
        chk("rst_resp_valid", {31'b0, bus.resp_valid}, 32'd0);
        chk("rst_resp_fault", {31'b0, bus.resp_fault}, 32'd0);
        chk("rst_resp_rdata", bus.resp_rdata,          32'd0);
        chk("rst_mem_en_w",   {31'b0, mem_en_w},       32'd0);
        chk("rst_mem_addr",   mem_addr,                32'd0);
        chk("rst_mem_wdata",  mem_wdata,               32'd0);
        #10;
        rst_n = 1'b1;

        // Basic word, byte and halfword traffic
        issue(1, F3_W,  32'h10, 32'hDEADBEEF, 0, 32'h0,        2, 1, 32'hDEADBEEF, 0, 0);
        issue(0, F3_W,  32'h10, 32'h0,        0, 32'hDEADBEEF, 2, 0, 32'h0,        0, 0);
        issue(1, F3_W,  32'h20, 32'h11223344, 0, 32'h0,        2, 1, 32'h11223344, 0, 0);
        issue(1, F3_B,  32'h22, 32'h000000AB, 0, 32'h0,        3, 1, 32'h11AB3344, 0, 0);
        issue(0, F3_B,  32'h22, 32'h0,        0, 32'hFFFFFFAB, 2, 0, 32'h0,        0, 0);
        issue(0, F3_BU, 32'h22, 32'h0,        0, 32'h000000AB, 2, 0, 32'h0,        0, 0);
        issue(0, F3_B,  32'h23, 32'h0,        0, 32'h00000011, 2, 0, 32'h0,        0, 0);
        issue(0, F3_H,  32'h20, 32'h0,        0, 32'h00003344, 2, 0, 32'h0,        0, 0);
        issue(1, F3_H,  32'h42, 32'h00008001, 0, 32'h0,        3, 1, 32'h80010000, 0, 0);
        issue(0, F3_H,  32'h42, 32'h0,        0, 32'hFFFF8001, 2, 0, 32'h0,        0, 0);
        issue(0, F3_HU, 32'h42, 32'h0,        0, 32'h00008001, 2, 0, 32'h0,        0, 0);
        issue(0, F3_W,  32'h40, 32'h0,        0, 32'h80010000, 2, 0, 32'h0,        0, 0);

        // Last legal word index
        issue(1, F3_W,  32'hFFC, 32'hCAFEF00D, 0, 32'h0,       2, 1, 32'hCAFEF00D, 0, 0);
        issue(0, F3_W,  32'hFFC, 32'h0,        0, 32'hCAFEF00D, 2, 0, 32'h0,       0, 0);

        // Faulting requests: misaligned, bad funct3, out of range
        issue(0, F3_W,  32'h13,   32'h0,        1, 32'h0, 1, 0, 32'h0, 0, 0);
        issue(1, F3_H,  32'h41,   32'h12345678, 1, 32'h0, 1, 0, 32'h0, 0, 0);
        issue(0, 3'd3,  32'h10,   32'h0,        1, 32'h0, 1, 0, 32'h0, 0, 0);
        issue(1, F3_W,  32'h1000, 32'h55555555, 1, 32'h0, 1, 0, 32'h0, 0, 0);
        issue(1, 3'd4,  32'h10,   32'h0,        1, 32'h0, 1, 0, 32'h0, 0, 0);

        // Back-to-back with req_valid held high
        issue(0, F3_W,  32'h10, 32'h0,        0, 32'hDEADBEEF, 2, 0, 32'h0,        0, 1);
        issue(1, F3_W,  32'h14, 32'h01234567, 0, 32'h0,        2, 1, 32'h01234567, 3, 1);
        issue(0, F3_W,  32'h14, 32'h0,        0, 32'h01234567, 2, 0, 32'h0,        3, 1);
        issue(1, F3_B,  32'h15, 32'h00000099, 0, 32'h0,        3, 1, 32'h01239967, 3, 1);
        issue(0, F3_HU, 32'h14, 32'h0,        0, 32'h00009967, 2, 0, 32'h0,        4, 1);
        issue(0, F3_W,  32'h13, 32'h0,        1, 32'h0,        1, 0, 32'h0,        3, 1);
        issue(0, F3_W,  32'h11, 32'h0,        1, 32'h0,        1, 0, 32'h0,        2, 1);
        issue(1, F3_H,  32'h16, 32'h0000ABCD, 0, 32'h0,        3, 1, 32'hABCD9967, 2, 0);
        drain();

        // Reset asserted during the WRITE cycle of an SB, before the falling edge
        @(negedge clk2);
        bus.req_valid  = 1'b1;
        bus.req_we     = 1'b1;
        bus.req_funct3 = F3_B;
        bus.req_addr   = 32'h40;
        bus.req_wdata  = 32'h00000055;
        $display("issue cyc=%0d SB addr=00000040 wdata=00000055 (reset during WRITE)", cyc);
        @(posedge clk2);
        #1;
        bus.req_valid = 1'b0;
        @(posedge clk2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_mem_en_w",   {31'b0, mem_en_w},       32'd0);
        chk("abort_ready",      {31'b0, bus.req_ready},  32'd1);
        chk("abort_resp_valid", {31'b0, bus.resp_valid}, 32'd0);
        chk("abort_resp_fault", {31'b0, bus.resp_fault}, 32'd0);
        chk("abort_resp_rdata", bus.resp_rdata,          32'd0);
        chk("abort_mem_addr",   mem_addr,                32'd0);
        chk("abort_mem_wdata",  mem_wdata,               32'd0);
        @(negedge clk2);
        #1;
        chk("abort_mem_word", data_mem[16], 32'h80010000);
        #3;
        rst_n = 1'b1;
        issue(0, F3_W, 32'h40, 32'h0, 0, 32'h80010000, 2, 0, 32'h0, 0, 0);
        drain();

        chk("resp_queue_empty",  exp_q.size(), 32'd0);
        chk("write_queue_empty", wr_q.size(),  32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
